// File: rtl/banked_fifo_drain_pkg.sv
// Shared types and helpers for the banked FIFO drain stage.
package banked_fifo_drain_pkg;

   // Lane count of the FIFO this drain is paired with
   localparam int unsigned LANES = 4;
   // Width of a lane count (0..LANES inclusive)
   localparam int unsigned CNT_W = $clog2(LANES) + 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } drain_state_e;

   // Number of consecutive set bits starting at lane 0; a hole ends the run
   function automatic logic [CNT_W-1:0] lead_ones(input logic [0:LANES-1] vec);
      logic [CNT_W-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int j = 0; j < LANES; j++) begin
         run = run & vec[j];
         if (run) n = n + CNT_W'(1);
      end
      return n;
   endfunction

   // Lanes 0..k-1 set, remaining lanes clear
   function automatic logic [0:LANES-1] prefix_mask(input logic [CNT_W-1:0] k);
      logic [0:LANES-1] m;
      m = '0;
      for (int j = 0; j < LANES; j++) begin
         m[j] = (CNT_W'(j) < k);
      end
      return m;
   endfunction

endpackage

// File: rtl/banked_fifo_drain_batch_timer.sv
// Saturating wait counter for partial batches: clear has priority over count.
module banked_fifo_drain_batch_timer #(
   parameter int unsigned MAX = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       inc,
   output logic [$clog2(MAX+1)-1:0]   cnt
);

   localparam int unsigned W = $clog2(MAX + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != W'(MAX))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/banked_fifo_drain.sv
// Pulls a contiguous prefix of FIFO lanes into a registered N-lane bundle,
// subject to downstream credit and a minimum-batch/timeout policy.
module banked_fifo_drain
   import banked_fifo_drain_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N         = LANES,
   parameter int unsigned MIN_BATCH = 2,
   parameter int unsigned TIMEOUT   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [0:N-1]            fifo_rd_ok,
   input  logic [WIDTH-1:0]        fifo_rd_data [N],
   output logic [0:N-1]            fifo_rd_en,
   input  logic [$clog2(N):0]      take_max,
   output logic [0:N-1]            out_valid,
   output logic [WIDTH-1:0]        out_data [N],
   input  logic                    out_ready,
   output logic [31:0]             drain_count
);

   localparam int unsigned KW = $clog2(N) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   drain_state_e     state_q, state_d;
   logic [0:N-1]     valid_q, valid_d;
   logic [WIDTH-1:0] data_q [N];
   logic [WIDTH-1:0] data_d [N];
   logic [31:0]      drain_q, drain_d;

   logic [KW-1:0]    avail;
   logic [KW-1:0]    tm_clamp;
   logic [KW-1:0]    k;
   logic [0:N-1]     k_mask;
   logic             free;
   logic             batch_ok;
   logic             load;
   logic             tmr_clr;
   logic             tmr_inc;
   logic [TW-1:0]    wait_cnt;

   // Lane count: leading valid lanes limited by clamped downstream credit
   always_comb begin
      avail    = lead_ones(fifo_rd_ok);
      tm_clamp = (take_max > KW'(N)) ? KW'(N) : take_max;
      k        = (avail < tm_clamp) ? avail : tm_clamp;
      k_mask   = prefix_mask(k);
   end

   // Load decision; credit-limited bundles go immediately since waiting cannot widen them
   always_comb begin
      free     = (state_q == EMPTY) || out_ready;
      batch_ok = (k >= KW'(MIN_BATCH))
              || (wait_cnt == TW'(TIMEOUT))
              || (k == tm_clamp);
      load     = free && !flush && !rst && (k != '0) && batch_ok;
      tmr_clr  = (k == '0) || load || flush;
      tmr_inc  = free && (k < KW'(MIN_BATCH)) && !load;
   end

   assign fifo_rd_en = load ? k_mask : '0;

   banked_fifo_drain_batch_timer #(
      .MAX (TIMEOUT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .inc (tmr_inc),
      .cnt (wait_cnt)
   );

   // Next bundle state: load, release on accept, or hold; flush empties
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      drain_d = drain_q;
      for (int j = 0; j < N; j++) data_d[j] = data_q[j];

      if (load) begin
         state_d = FULL;
         valid_d = k_mask;
         drain_d = drain_q + 32'(k);
         for (int j = 0; j < N; j++) begin
            data_d[j] = k_mask[j] ? fifo_rd_data[j] : '0;
         end
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
         valid_d = '0;
         for (int j = 0; j < N; j++) data_d[j] = '0;
      end

      if (flush) begin
         state_d = EMPTY;
         valid_d = '0;
         for (int j = 0; j < N; j++) data_d[j] = '0;
      end
   end

   // Bundle, FSM and drain counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         valid_q <= '0;
         drain_q <= '0;
         for (int j = 0; j < N; j++) data_q[j] <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         drain_q <= drain_d;
         for (int j = 0; j < N; j++) data_q[j] <= data_d[j];
      end
   end

   assign out_valid   = valid_q;
   assign out_data    = data_q;
   assign drain_count = drain_q;

endmodule

// File: doc/banked_fifo_drain.md
Name: banked_fifo_drain

Overview:
- Consumer for the N-lane sequential-port banked FIFO read interface.
- Each cycle it pulls a contiguous prefix of up to N entries from the FIFO read ports and registers them as one N-lane bundle for the downstream stage (decode/rename or issue).
- It applies a downstream credit limit and a minimum-batch policy with a timeout, so narrow bundles are not issued while more entries are about to arrive.

Parameters:
- WIDTH, 32, bits per entry.
- N, 4, lane count; power of 2, must equal the FIFO's N.
- MIN_BATCH, 2, minimum lanes before a bundle loads without waiting; 1..N.
- TIMEOUT, 3, cycles a partial batch (0 < k < MIN_BATCH) may wait before it loads anyway; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; clears the bundle and timer.
- fifo_rd_ok  in  [0:N-1]  FIFO lane j has data (show-ahead).
- fifo_rd_data  in  WIDTH x N (unpacked [N])  FIFO head data per lane.
- fifo_rd_en  out  [0:N-1]  dequeue strobe; always a contiguous prefix from lane 0.
- take_max  in  $clog2(N)+1  downstream free slots this cycle; values > N are clamped to N.
- out_valid  out  [0:N-1]  bundle lane valid; always a contiguous prefix.
- out_data  out  WIDTH x N (unpacked [N])  bundle data; invalid lanes drive 0.
- out_ready  in  1  downstream accepts the whole bundle this cycle.
- drain_count  out  32  total entries dequeued since reset; wraps modulo 2^32.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - out_valid = 0, out_data = 0, drain_count = 0.
  - wait_cnt = 0, state = EMPTY.
  - fifo_rd_en is combinationally 0 while rst = 1.
- Lane count k (combinational):
  - avail = number of leading ones in fifo_rd_ok.
  - k = min(avail, min(take_max, N)).
  - A hole in fifo_rd_ok stops counting; lanes after the hole are ignored.
- Free condition: free = (state == EMPTY) || out_ready.
- load (combinational): asserted when all of the following hold:
  - free, !flush, !rst;
  - k ≥ MIN_BATCH, or (k > 0 and wait_cnt == TIMEOUT), or (k > 0 and k == take_max_clamped).
  - The last case means credit, not data, is the limit, so waiting cannot help.
- fifo_rd_en[j] = load && (j < k), combinational. Zero-latency dequeue; the FIFO advances on the same edge.
- On load edge:
  - out_data[j] ← fifo_rd_data[j] for j < k, else 0.
  - out_valid ← prefix mask of k.
  - state ← FULL; drain_count += k; wait_cnt ← 0.
- FULL && out_ready && !load: state ← EMPTY, out_valid ← 0, out_data ← 0.
- FULL && !out_ready: hold the bundle stable; no dequeue.
- Timer wait_cnt, width $clog2(TIMEOUT+1):
  - Increments, saturating at TIMEOUT, while free && 0 < k < MIN_BATCH && !load.
  - Resets to 0 when k == 0, on load, or on flush.
- FSM states: EMPTY (no bundle held), FULL (bundle held). Transitions:
  - EMPTY→FULL on load.
  - FULL→FULL on out_ready && load (back-to-back, 1 bundle/cycle).
  - FULL→EMPTY on out_ready && !load.
- Flush:
  - Next edge: out_valid = 0, out_data = 0, state = EMPTY, wait_cnt = 0.
  - fifo_rd_en = 0 in the flush cycle.
  - drain_count is not cleared.
  - The FIFO is cleared separately by its own clear input.
- Simultaneous rst and flush: rst wins; both yield the same state except drain_count.
- Latency: FIFO head to out_valid is 1 cycle.
- Throughput: N entries/cycle at steady state with out_ready held high.

Decomposition:
- Shared package: drain FSM state enum {EMPTY, FULL}; a function lead_ones(vec) returning $clog2(N)+1 bits; a function prefix_mask(k) returning [0:N-1].
- Sub-module: none required. The batch timer may be a separate sub-module, drain_batch_timer (count/saturate/clear), reused by other buffering blocks.

Test Plan:
- Configuration for all scenarios: N=4, MIN_BATCH=2, TIMEOUT=3.
- Full burst: rd_ok=1111, take_max=4, out_ready=1 → rd_en=1111 each cycle; next cycle out_valid=1111 with data 0..3; drain_count +4 per cycle.
- Hole handling: rd_ok=1101, take_max=4 → k=2; rd_en=1100; out_valid=1100; lane 3 data is not taken.
- Timeout: rd_ok=1000 held, take_max=4 → rd_en=0 for 3 cycles (wait_cnt 1,2,3); 4th cycle rd_en=1000; next cycle out_valid=1000.
- Credit limit: rd_ok=1111, take_max=1 → immediate load; rd_en=1000; out_valid=1000, with no waiting.
- Backpressure: bundle held with out_ready=0 for 5 cycles → out_valid/out_data stable and rd_en=0; out_ready=1 with rd_ok=1111 → back-to-back reload on the same edge.
- Flush and reset: flush while FULL with rd_ok=1111 → rd_en=0; next cycle out_valid=0 and drain_count unchanged. rst mid-burst → all outputs 0 and drain_count=0 on the next edge.
